call_ret_ctrl: RTL

CALL_RET_CTRL -- requirements
Module: call_ret_ctrl

---
 rtl/call_ret_ctrl_if.sv | 26 ++
 rtl/call_ret_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/call_ret_ctrl_if.sv
// rtl/call_ret_ctrl_if.sv - sequencer/stack/PC bundle for the call-return controller
interface call_ret_ctrl_if;
  logic       CALL;
  logic       RET;
  logic [7:0] PC_IN;
  logic [7:0] TARGET;
  logic [7:0] STK_DATA;
  logic       PUSH;
  logic       POP;
  logic [7:0] VALUE;
  logic       PC_LOAD;
  logic [7:0] PC_OUT;
  logic       BUSY;
  logic [7:0] DEPTH_CNT;
  logic [1:0] FAULT;

  modport master (
    output CALL, RET, PC_IN, TARGET, STK_DATA,
    input  PUSH, POP, VALUE, PC_LOAD, PC_OUT, BUSY, DEPTH_CNT, FAULT
  );

  modport slave (
    input  CALL, RET, PC_IN, TARGET, STK_DATA,
    output PUSH, POP, VALUE, PC_LOAD, PC_OUT, BUSY, DEPTH_CNT, FAULT
  );
endinterface

// File: rtl/call_ret_ctrl.sv
// rtl/call_ret_ctrl.sv - call/return sequencer driving an external return-address stack
module call_ret_ctrl #(
  parameter logic [7:0] DEPTH  = 8'd255,
  parameter int         RD_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  call_ret_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_ST = 3'd1,
    POP_ST  = 3'd2,
    WAIT_ST = 3'd3,
    LOAD_ST = 3'd4
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t     state, state_nxt;
  logic       armed;
  logic [1:0] wait_cnt;
  logic [7:0] value_r;
  logic [7:0] pc_r;
  logic [7:0] depth_cnt;
  logic [1:0] fault_r;

  // armed stays low for the first edge after reset release so no request is taken there
  logic call_req, ret_req, can_push, can_pop;
  assign call_req = armed && bus.CALL && !bus.RET;
  assign ret_req  = armed && bus.RET && !bus.CALL;
  assign can_push = depth_cnt < DEPTH;
  assign can_pop  = depth_cnt != 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (call_req && can_push) begin
          state_nxt = PUSH_ST;
        end else if (ret_req && can_pop) begin
          state_nxt = POP_ST;
        end
      end
      PUSH_ST: state_nxt = LOAD_ST;
      POP_ST:  state_nxt = WAIT_ST;
      WAIT_ST: begin
        if (wait_cnt == 2'd0) begin
          state_nxt = LOAD_ST;
        end
      end
      LOAD_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.PUSH    = (state == PUSH_ST);
    bus.POP     = (state == POP_ST);
    bus.PC_LOAD = (state == LOAD_ST);
    bus.BUSY    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed     <= 1'b0;
      wait_cnt  <= 2'd0;
      value_r   <= 8'h00;
      pc_r      <= 8'h00;
      depth_cnt <= 8'h00;
      fault_r   <= 2'b00;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (call_req) begin
            if (can_push) begin
              value_r <= bus.PC_IN + 8'd1;
              pc_r    <= bus.TARGET;
            end else begin
              fault_r[0] <= 1'b1;
            end
          end else if (ret_req && !can_pop) begin
            fault_r[1] <= 1'b1;
          end
        end
        PUSH_ST: depth_cnt <= depth_cnt + 8'd1;
        POP_ST: begin
          depth_cnt <= depth_cnt - 8'd1;
          wait_cnt  <= WAIT_INIT;
        end
        WAIT_ST: begin
          // stack read data is only valid on the edge where the count expires
          if (wait_cnt == 2'd0) begin
            pc_r <= bus.STK_DATA;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.VALUE     = value_r;
  assign bus.PC_OUT    = pc_r;
  assign bus.DEPTH_CNT = depth_cnt;
  assign bus.FAULT     = fault_r;

endmodule
